rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the single register-file write port between two producers: port A (ALU writeback) and port B (load/memory unit).
//  Each port has a one-entry holding slot. A round-robin arbiter picks one slot per cycle.
//  The block drives registered write-port outputs and wr_src, the select for the 3-bit destination-address 2:1 mux (0 = A, 1 = B).
//  It sits between the execute/memory stages and the register file.
// PARAMETERS
//  DATA_W        32  width of write data
//  ADDR_W        3   width of register address (8 registers)
//  ZERO_DISCARD  1   1: writes to address 0 are accepted and drained but never assert wr_en
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  a_valid    in   1       port A write request
//  a_ready    out  1       port A slot can accept this cycle
//  a_addr     in   ADDR_W  port A destination register
//  a_data     in   DATA_W  port A write data
//  b_valid    in   1       port B write request
//  b_ready    out  1       port B slot can accept this cycle
//  b_addr     in   ADDR_W  port B destination register
//  b_data     in   DATA_W  port B write data
//  wr_en      out  1       register-file write enable (registered)
//  wr_addr    out  ADDR_W  register-file write address (registered)
//  wr_data    out  DATA_W  register-file write data (registered)
//  wr_src     out  1       granted port of current write (0 = A, 1 = B), drives the address mux select
//  pending    out  2       {B slot full, A slot full}
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - wr_en=0, wr_addr=0, wr_data=0, wr_src=0, both slots empty, pending=0.
//   - last_grant=B, so A wins the first contention.
//   - Reset mid-operation discards slot contents without producing a write.
//  Handshake:
//   - A transfer occurs when x_valid & x_ready at a rising edge; addr/data are captured into the slot.
//   - x_ready = !full_x | grant_x. This is combinational from state only, never from x_valid.
//   - A full slot that is granted this cycle can reload at the same edge (no bubble).
//  Arbitration (combinational from slot state):
//   - Only one slot full: that slot is granted.
//   - Both slots full: the port opposite last_grant wins; last_grant updates on every grant.
//   - Worst-case wait for a full slot is 1 cycle.
//   - Same-address contention: when both slots are full with equal addr and both were loaded at the same edge, A is granted first, then B. The B value is the final register value, regardless of last_grant.
//  Output stage (registered): on a grant at edge k, wr_en, wr_addr, wr_data and wr_src update at edge k.
//   - wr_en = 1 unless ZERO_DISCARD && addr==0.
//   - No grant at edge k -> wr_en=0; wr_addr/wr_data/wr_src hold their previous values.
//  Latency: accept at edge k -> write visible after edge k+1 if uncontended, k+2 if it loses arbitration.
//  Throughput: one write per cycle sustained. Both ports streaming -> strict alternation A,B,A,B.
//  Invariant: every accepted request produces exactly one grant, in per-port acceptance order.
// STRUCTURE
//  Shared package: ADDR_W/DATA_W defaults, localparams SRC_A=1'b0 and SRC_B=1'b1.
//  Sub-module rf_wr_slot: one-entry holding register with valid/ready.
//   - Ports: clk, rst_n, in_valid, in_ready, in_addr, in_data, grant, full, out_addr, out_data.
//   - Instantiated twice.
//  Top level holds the arbiter, the last_grant flop, the same-edge-load tie flag and the output registers.
// TESTING
//  1. Reset: assert rst_n=0 mid-stream with both slots full -> all outputs 0, pending=00 asynchronously; no wr_en after release.
//  2. Single port: A sends addr=3, data=0x1234 -> wr_en=1, addr=3, data=0x1234, wr_src=0 one cycle after accept; a_ready stays 1.
//  3. Contention: A (addr=1) and B (addr=2) valid every cycle for 8 cycles -> writes alternate A,B,... starting with A; 8 writes total; no drops.
//  4. Same address: A (addr=5, data=0xAA) and B (addr=5, data=0xBB) accepted at the same edge -> write 0xAA then 0xBB on consecutive cycles.
//  5. Zero register: B writes addr=0 with ZERO_DISCARD=1 -> slot drains, wr_en stays 0, b_ready returns 1.
//  6. Back-pressure: hold B full while A streams -> b_ready=0 only while B is full and not granted; b_ready drops for at most 1 cycle.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and write-source encodings for the register-file write arbiter.
package rf_write_arbiter_pkg;
  localparam int   DATA_W_DEF = 32;
  localparam int   ADDR_W_DEF = 3;
  localparam logic SRC_A      = 1'b0;
  localparam logic SRC_B      = 1'b1;
endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding register with valid/ready; reloads on the same edge it is drained.
module rf_wr_slot
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  logic              full_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              load_s;

  assign in_ready = !full_r || grant;
  assign load_s   = in_valid && in_ready;
  assign full     = full_r;
  assign out_addr = addr_r;
  assign out_data = data_r;

  // Slot occupancy and payload capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      full_r <= 1'b1;
      addr_r <= in_addr;
      data_r <= in_data;
    end else if (grant) begin
      full_r <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (A) and load unit (B).
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [1:0]        pending
);

  logic              full_a_s, full_b_s;
  logic              grant_a_s, grant_b_s;
  logic [ADDR_W-1:0] slot_a_addr_s, slot_b_addr_s, sel_addr_s;
  logic [DATA_W-1:0] slot_a_data_s, slot_b_data_s, sel_data_s;
  logic              sel_src_s;
  logic              last_grant_r, tie_r;
  logic              wr_en_r, wr_src_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_addr(a_addr), .in_data(a_data), .grant(grant_a_s), .full(full_a_s),
    .out_addr(slot_a_addr_s), .out_data(slot_a_data_s)
  );

  rf_wr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_addr(b_addr), .in_data(b_data), .grant(grant_b_s), .full(full_b_s),
    .out_addr(slot_b_addr_s), .out_data(slot_b_data_s)
  );

  // Grant selection; a same-edge same-address pair always drains A first so B's value lands last
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (full_a_s && full_b_s) begin
      if (tie_r || (last_grant_r == SRC_B)) begin
        grant_a_s = 1'b1;
      end else begin
        grant_b_s = 1'b1;
      end
    end else if (full_a_s) begin
      grant_a_s = 1'b1;
    end else if (full_b_s) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Winning slot's payload, steered by the same select that drives wr_src
  always_comb begin
    sel_src_s  = SRC_A;
    sel_addr_s = slot_a_addr_s;
    sel_data_s = slot_a_data_s;
    if (grant_b_s) begin
      sel_src_s  = SRC_B;
      sel_addr_s = slot_b_addr_s;
      sel_data_s = slot_b_data_s;
    end else begin
      sel_src_s  = SRC_A;
      sel_addr_s = slot_a_addr_s;
      sel_data_s = slot_a_data_s;
    end
  end

  // Round-robin history and same-edge same-address tie flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= SRC_B;
      tie_r        <= 1'b0;
    end else begin
      if (grant_a_s || grant_b_s) begin
        last_grant_r <= sel_src_s;
      end
      tie_r <= a_valid && a_ready && b_valid && b_ready && (a_addr == b_addr);
    end
  end

  // Registered write port; payload holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      wr_src_r  <= SRC_A;
    end else if (grant_a_s || grant_b_s) begin
      wr_en_r   <= !(ZERO_DISCARD && (sel_addr_s == {ADDR_W{1'b0}}));
      wr_addr_r <= sel_addr_s;
      wr_data_r <= sel_data_s;
      wr_src_r  <= sel_src_s;
    end else begin
      wr_en_r <= 1'b0;
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign wr_src  = wr_src_r;
  assign pending = {full_b_s, full_a_s};

endmodule
